// File: rtl/seg7_pkg.sv
// seg7_pkg: segment bit positions and hex glyph table for the 7-segment scanner
package seg7_pkg;
  localparam int SEG_A = 7;
  localparam int SEG_B = 6;
  localparam int SEG_C = 5;
  localparam int SEG_D = 4;
  localparam int SEG_E = 3;
  localparam int SEG_F = 2;
  localparam int SEG_G = 1;
  localparam int SEG_DP = 0;
  localparam logic [15:0][6:0] GLYPHS = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };
  function automatic logic [6:0] seg7_glyph(input logic [3:0] n);
    return GLYPHS[n];
  endfunction
endpackage

// File: rtl/seg7_lz_mask.sv
// seg7_lz_mask: dark mask for leading zeros via an MSB-down prefix-OR of nonzero nibbles
module seg7_lz_mask #(
  parameter int N_DIGITS = 8
) (
  input  logic [4*N_DIGITS-1:0] data,
  input  logic                  lz_blank,
  output logic [N_DIGITS-1:0]   dark
);
  always_comb begin
    logic nz;
    nz = 1'b0;
    dark = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      nz = nz | (|data[4*i +: 4]);
      dark[i] = lz_blank && i != 0 && !nz;
    end
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with shadowed content, blanking, blink and PWM
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS      = 8,
  parameter int DIV_W         = 17,
  parameter int BLINK_W       = 26,
  parameter int AN_ACTIVE_LOW = 1,
  parameter int CA_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] upd_data,
  input  logic [N_DIGITS-1:0]   upd_dp,
  input  logic [N_DIGITS-1:0]   upd_en,
  input  logic [N_DIGITS-1:0]   upd_blink,
  input  logic                  upd_valid,
  output logic                  upd_ack,
  input  logic                  lz_blank,
  input  logic [3:0]            bright,
  output logic                  frame_start,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            ca
);
  localparam int CUR_W = $clog2(N_DIGITS);
  localparam logic [CUR_W-1:0] LAST = CUR_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW != 0 ? '1 : '0;
  localparam logic [7:0] CA_OFF = CA_ACTIVE_LOW != 0 ? '1 : '0;
  logic [DIV_W-1:0] pcnt;
  logic [CUR_W-1:0] cur;
  logic [BLINK_W-1:0] bcnt;
  logic [4*N_DIGITS-1:0] data_sh;
  logic [N_DIGITS-1:0] dp_sh, en_sh, blink_sh, lz_dark, sel;
  logic tick, last, cap, lit;
  logic [3:0] nib;
  seg7_lz_mask #(.N_DIGITS(N_DIGITS)) u_lz (.data(data_sh), .lz_blank(lz_blank), .dark(lz_dark));
  always_comb begin
    tick = &pcnt;
    last = cur == LAST;
    cap = tick && last && upd_valid;
    nib = data_sh[4*cur +: 4];
    sel = N_DIGITS'(1) << cur;
    lit = en_sh[cur] && !lz_dark[cur] && !(blink_sh[cur] && bcnt[BLINK_W-1])
          && pcnt[DIV_W-1 -: 4] < bright;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      cur <= '0;
      bcnt <= '0;
      data_sh <= '0;
      dp_sh <= '0;
      en_sh <= '0;
      blink_sh <= '0;
      upd_ack <= 1'b0;
      frame_start <= 1'b0;
      an <= AN_OFF;
      ca <= CA_OFF;
    end else begin
      pcnt <= pcnt + 1'b1;
      bcnt <= bcnt + 1'b1;
      if (tick) cur <= last ? '0 : cur + 1'b1;
      frame_start <= tick && last;
      upd_ack <= cap;
      if (cap) begin
        data_sh <= upd_data;
        dp_sh <= upd_dp;
        en_sh <= upd_en;
        blink_sh <= upd_blink;
      end
      an <= AN_OFF ^ (lit ? sel : '0);
      ca <= CA_OFF ^ {seg7_glyph(nib), dp_sh[cur]};
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized scoreboard bench against a time-based display model
module tb_seg7_scan_ctrl;
  localparam int N = 6;
  logic clk = 0, reset = 1;
  logic [4*N-1:0] upd_data = '0;
  logic [N-1:0] upd_dp = '0, upd_en = '0, upd_blink = '0;
  logic upd_valid = 0, lz_blank = 0;
  logic [3:0] bright = 0;
  logic upd_ack, frame_start;
  logic [N-1:0] an;
  logic [7:0] ca;
  typedef struct packed {logic [N-1:0] an; logic [7:0] ca; logic ack; logic fs;} obs_t;
  obs_t q[$];
  int checks = 0, errors = 0, t = 0;
  bit captured;
  logic [4*N-1:0] m_data;
  logic [N-1:0] m_dp, m_en, m_blink;
  logic [6:0] font [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  always #5 clk = ~clk;
  seg7_scan_ctrl #(.N_DIGITS(N), .DIV_W(4), .BLINK_W(8), .AN_ACTIVE_LOW(1), .CA_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .upd_data(upd_data), .upd_dp(upd_dp), .upd_en(upd_en),
    .upd_blink(upd_blink), .upd_valid(upd_valid), .upd_ack(upd_ack), .lz_blank(lz_blank),
    .bright(bright), .frame_start(frame_start), .an(an), .ca(ca));
  task automatic cyc();
    obs_t e;
    int p, d;
    bit nz, lit;
    captured = 0;
    if (reset) begin
      e.an = 6'h3F; e.ca = 8'hFF; e.ack = 0; e.fs = 0;
      t = 0; m_data = '0; m_dp = '0; m_en = '0; m_blink = '0;
    end else begin
      p = t % 16;
      d = (t / 16) % N;
      nz = 0;
      for (int j = d; j < N; j++) if (m_data[4*j +: 4] != 0) nz = 1;
      lit = m_en[d] && !(lz_blank && d != 0 && !nz) && !(m_blink[d] && (t % 256) >= 128) && p < int'(bright);
      e.an = lit ? ~(6'(1) << d) : 6'h3F;
      e.ca = ~{font[m_data[4*d +: 4]], m_dp[d]};
      e.fs = (t % 96) == 95;
      e.ack = e.fs && upd_valid;
      if (e.ack) begin
        m_data = upd_data; m_dp = upd_dp; m_en = upd_en; m_blink = upd_blink;
        captured = 1;
      end
      t++;
    end
    q.push_back(e);
    @(negedge clk);
  endtask
  task automatic run(input int n);
    repeat (n) cyc();
  endtask
  task automatic wait_cap(input string tag);
    captured = 0;
    for (int i = 0; i < 300 && !captured; i++) cyc();
    checks++;
    if (!captured) begin
      errors++;
      $display("FAIL %s: no capture within 300 cycles @%0t", tag, $time);
    end
  endtask
  task automatic update(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] en, input logic [5:0] bl);
    upd_data = d; upd_dp = dp; upd_en = en; upd_blink = bl; upd_valid = 1;
    wait_cap("update");
    upd_valid = 0;
  endtask
  initial forever begin
    obs_t e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({an, ca, upd_ack, frame_start} !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got an=%h ca=%h ack=%b fs=%b, want an=%h ca=%h ack=%b fs=%b",
                 $time, an, ca, upd_ack, frame_start, e.an, e.ca, e.ack, e.fs);
      end
    end
  end
  initial begin
    @(negedge clk);
    run(3);
    checks++;
    if (an !== 6'h3F || ca !== 8'hFF || upd_ack !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset state: an=%h ca=%h ack=%b fs=%b", an, ca, upd_ack, frame_start);
    end
    reset = 0;
    run(40);
    bright = 15;
    update(24'h12AB0F, 6'h00, 6'h3F, 6'h00);
    run(192);
    lz_blank = 1;
    update(24'h000450, 6'h00, 6'h3F, 6'h00);
    run(96);
    update(24'h000000, 6'h00, 6'h3F, 6'h00);
    run(96);
    lz_blank = 0;
    update(24'h123456, 6'h15, 6'h3F, 6'h00);
    bright = 4;
    run(96);
    bright = 0;
    run(96);
    bright = 15;
    update(24'h876543, 6'h00, 6'h3F, 6'h02);
    run(512);
    for (int k = 0; k < 12; k++) begin
      lz_blank = 1'($urandom);
      bright = 4'($urandom);
      for (int i = 0, w = $urandom_range(0, 150); i < w; i++) begin
        if ($urandom_range(0, 31) == 0) bright = 4'($urandom);
        cyc();
      end
      update(24'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
      run($urandom_range(0, 96));
    end
    bright = 15;
    lz_blank = 0;
    upd_data = 24'hFEDCBA; upd_dp = 6'h2A; upd_en = 6'h3F; upd_blink = 6'h00;
    for (int i = 0; i < 200 && ((t / 16) % N) != 1; i++) cyc();
    upd_valid = 1;
    for (int i = 0; i < 200 && ((t / 16) % N) != 3; i++) cyc();
    reset = 1;
    run(2);
    reset = 0;
    wait_cap("reset recapture");
    upd_valid = 0;
    run(100);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
